// File: rtl/axis_dma_unpacker.sv
// axis_dma_unpacker: buffers DMA words in a 2-entry FIFO, unpacks them LSB-first into narrow beats,
// regenerates frame boundaries on the beat stream and flags short/long input frames.
module axis_dma_unpacker #(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int FRAME_BYTES    = 784
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axis_tvalid,
  input  logic [IN_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [OUT_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  input  logic                      err_clr,
  output logic                      err_short,
  output logic                      err_long,
  output logic                      frame_done
);
  localparam int RATIO       = IN_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int FRAME_WORDS = FRAME_BYTES / RATIO;
  localparam int IW          = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int WW          = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam int BW          = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(RATIO - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t                     occ_q, occ_d;
  logic [IN_DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [IW-1:0]            idx_q;
  logic [WW-1:0]            wcnt_q;
  logic [BW-1:0]            bcnt_q;
  logic                     err_short_q, err_long_q;
  logic                     push, beat, pop, short_hit, long_hit;

  assign s_axis_tready = ~rst & (occ_q != TWO);
  assign m_axis_tvalid = occ_q != EMPTY;
  assign m_axis_tlast  = bcnt_q == BEAT_LAST;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign pop           = beat & (idx_q == IDX_LAST);
  assign frame_done    = beat & m_axis_tlast;
  assign short_hit     = push & s_axis_tlast & (wcnt_q != WORD_LAST);
  assign long_hit      = push & ~s_axis_tlast & (wcnt_q == WORD_LAST);
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;

  // A push coinciding with the final-byte pop can only happen from ONE, so the new word becomes head.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push & ~pop) begin
      occ_d  = occ_q == EMPTY ? ONE : TWO;
      head_d = occ_q == EMPTY ? s_axis_tdata : head_q;
      tail_d = occ_q == EMPTY ? tail_q : s_axis_tdata;
    end else if (pop & ~push) begin
      occ_d  = occ_q == TWO ? ONE : EMPTY;
      head_d = tail_q;
    end else if (pop & push) begin
      head_d = s_axis_tdata;
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < RATIO; i++)
      if (idx_q == IW'(i)) m_axis_tdata = head_q[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= EMPTY;
      idx_q       <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      idx_q       <= beat ? (pop ? '0 : idx_q + 1'b1) : idx_q;
      bcnt_q      <= beat ? (m_axis_tlast ? '0 : bcnt_q + 1'b1) : bcnt_q;
      wcnt_q      <= push ? ((s_axis_tlast | (wcnt_q == WORD_LAST)) ? '0 : wcnt_q + 1'b1) : wcnt_q;
      err_short_q <= short_hit | (err_short_q & ~err_clr);
      err_long_q  <= long_hit | (err_long_q & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end
endmodule

// File: tb/tb_axis_dma_unpacker.sv
// tb_axis_dma_unpacker: scoreboard bench; expected beats are queued at word accept and checked by a monitor.
module tb_axis_dma_unpacker;
  logic        clk = 0;
  logic        rst = 1;
  logic        s_axis_tvalid = 0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 0;
  logic        err_clr = 0;
  logic        err_short, err_long, frame_done;

  int          checks = 0, fails = 0, mbytes = 0, cyc = 0;
  logic [8:0]  exp_q[$];
  int          beat_cyc[$];
  bit          rnd_ready = 0;

  axis_dma_unpacker #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(8), .FRAME_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .err_clr(err_clr), .err_short(err_short), .err_long(err_long), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rnd_ready) #1 m_axis_tready = 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each transferred beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e[7:0]);
          chk("beat_tlast", m_axis_tlast, e[8]);
          chk("beat_frame_done", frame_done, e[8]);
        end
      end else begin
        chk("idle_frame_done", frame_done, 0);
      end
    end
  end

  // Expected beats of a word: LSB byte first, tlast on every 8th beat since reset.
  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    s_axis_tvalid = 1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 200);
    if (!s_axis_tready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: tready 0 after %0d cycles, expected 1", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({1'((mbytes % 8) == 7), d[8*i +: 8]});
        mbytes++;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    m_axis_tready = 0;
    err_clr = 0;
    exp_q.delete();
    mbytes = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_long", err_long, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    rst = 0;
    #1;
    chk("post_rst_s_tready", s_axis_tready, 1);

    // Normal frame
    m_axis_tready = 1;
    send_word(32'h44332211, 0);
    chk("latency_tvalid", m_axis_tvalid, 1);
    chk("latency_tdata", m_axis_tdata, 8'h11);
    send_word(32'h88776655, 1);
    drain();
    chk("normal_err_short", err_short, 0);
    chk("normal_err_long", err_long, 0);

    // Backpressure
    do_reset();
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 1);
    chk("bp_s_tready", s_axis_tready, 0);
    chk("bp_hold_data", m_axis_tdata, 8'h11);
    s_axis_tvalid = 1;
    s_axis_tdata  = 32'hCCBBAA99;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", m_axis_tdata, 8'h11);
      chk("bp_hold_valid", m_axis_tvalid, 1);
      chk("bp_s_tready", s_axis_tready, 0);
    end
    m_axis_tready = 1;
    send_word(32'hCCBBAA99, 0);
    drain();

    // Concurrent push/pop: output must be continuous for 16 beats
    do_reset();
    m_axis_tready = 1;
    beat_cyc.delete();
    send_word(32'h04030201, 0);
    send_word(32'h08070605, 1);
    send_word(32'h0C0B0A09, 0);
    send_word(32'h100F0E0D, 1);
    drain();
    chk("cont_beats", beat_cyc.size(), 16);
    if (beat_cyc.size() == 16) chk("cont_span", beat_cyc[15] - beat_cyc[0], 15);

    // Short frame and error clear
    do_reset();
    m_axis_tready = 1;
    send_word(32'hDEADBEEF, 1);
    chk("short_set", err_short, 1);
    chk("short_no_long", err_long, 0);
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    chk("short_cleared", err_short, 0);
    drain();

    // Long frame
    do_reset();
    m_axis_tready = 1;
    send_word(32'h13121110, 0);
    chk("long_after1", err_long, 0);
    send_word(32'h17161514, 0);
    chk("long_after2", err_long, 1);
    send_word(32'h1B1A1918, 0);
    drain();
    chk("long_no_short", err_short, 0);

    // Mid-frame reset after 5 beats
    do_reset();
    send_word(32'h24232221, 0);
    send_word(32'h28272625, 1);
    m_axis_tready = 1;
    repeat (5) @(posedge clk);
    #1;
    m_axis_tready = 0;
    rst = 1;
    exp_q.delete();
    mbytes = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tlast", m_axis_tlast, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_s_tready", s_axis_tready, 0);
    rst = 0;
    #1;
    chk("mid_rst_release_s_tready", s_axis_tready, 1);
    m_axis_tready = 1;
    send_word(32'h34333231, 0);
    send_word(32'h38373635, 1);
    drain();

    // Randomized traffic with random output backpressure
    do_reset();
    rnd_ready = 1;
    for (int f = 0; f < 12; f++) begin
      for (int w = 0; w < 2; w++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_word($urandom, 1'(w == 1));
      end
    end
    rnd_ready = 0;
    @(posedge clk);
    #2;
    m_axis_tready = 1;
    drain();
    chk("rand_err_short", err_short, 0);
    chk("rand_err_long", err_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
